// File: rtl/fastserial_pkg.sv
// Shared constants and FSM state types for the fast-serial device-side link.
// Frame is start(0), 8 data bits LSB first, source bit; the line idles high.
package fastserial_pkg;
   localparam int   DATA_BITS   = 8;
   localparam int   FRAME_BITS  = 10;
   localparam logic START_LEVEL = 1'b0;
   localparam logic IDLE_LEVEL  = 1'b1;

   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_SRC} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT} tx_state_t;
endpackage

// File: rtl/fastserial_edge_sync.sv
// Synchronises an async clock-like input and emits registered one-cycle rise/fall pulses.
// Latency: pulses appear SYNC_STAGES+1 cycles after the pin edge; no backpressure.
// Backpressure: none, free-running.
module fastserial_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Reset to the idle-high level so a low line after reset only looks like a fall.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_q <= '1;
         dly_q  <= 1'b1;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
         dly_q  <= sync_s;
         o_rise <= sync_s & ~dly_q;
         o_fall <= ~sync_s & dly_q;
      end
   end
endmodule

// File: rtl/fastserial_target.sv
// Device-side fast-serial endpoint: receives frames on FSDI, sends on FSDO, drives FSCTS.
// Latency: FSCLK pin edge to o_fsdo change is SYNC_STAGES+2 cycles; rx byte 1 cycle after src bit.
// Backpressure: single-entry rx buffer (overrun pulse when full); tx accepts only when idle.
module fastserial_target
   import fastserial_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic TX_SOURCE   = 1'b0
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_fsclk,
   input  logic       i_fsdi,
   output logic       o_fsdo,
   output logic       o_fscts,
   output logic [7:0] o_rx_data,
   output logic       o_rx_src,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_rx_overrun,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_valid,
   output logic       o_tx_ready
);
   logic fs_rise, fs_fall;
   logic [SYNC_STAGES-1:0] fsdi_q;
   logic fsdi_s;

   fastserial_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_async   (i_fsclk),
      .o_rise    (fs_rise),
      .o_fall    (fs_fall)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) fsdi_q <= {SYNC_STAGES{IDLE_LEVEL}};
      else            fsdi_q <= {fsdi_q[SYNC_STAGES-2:0], i_fsdi};
   end
   assign fsdi_s = fsdi_q[SYNC_STAGES-1];

   rx_state_t rx_state, rx_next;
   logic [2:0] rx_cnt;
   logic [DATA_BITS-1:0] rx_shift;
   logic rx_done;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) rx_state <= RX_IDLE;
      else            rx_state <= rx_next;
   end

   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         RX_IDLE: if (fs_rise && fsdi_s == START_LEVEL) rx_next = RX_DATA;
         RX_DATA: if (fs_rise && rx_cnt == 3'(DATA_BITS - 1)) rx_next = RX_SRC;
         RX_SRC:  if (fs_rise) rx_next = RX_IDLE;
         default: rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_done = (rx_state == RX_SRC) && fs_rise;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rx_cnt   <= '0;
         rx_shift <= '0;
      end else if (rx_state == RX_IDLE) begin
         rx_cnt <= '0;
      end else if (rx_state == RX_DATA && fs_rise) begin
         rx_shift <= {fsdi_s, rx_shift[DATA_BITS-1:1]};
         rx_cnt   <= rx_cnt + 3'd1;
      end
   end

   // An accept in the completion cycle frees the slot, so the new frame loads instead of overrunning.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_rx_data    <= '0;
         o_rx_src     <= 1'b0;
         o_rx_valid   <= 1'b0;
         o_rx_overrun <= 1'b0;
         o_fscts      <= 1'b1;
      end else begin
         o_rx_overrun <= 1'b0;
         if (rx_done) begin
            if (!o_rx_valid || i_rx_ready) begin
               o_rx_data  <= rx_shift;
               o_rx_src   <= fsdi_s;
               o_rx_valid <= 1'b1;
            end else begin
               o_rx_overrun <= 1'b1;
            end
         end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end
         o_fscts <= (rx_state == RX_IDLE) && !o_rx_valid;
      end
   end

   tx_state_t tx_state, tx_next;
   logic [3:0] tx_cnt;
   logic [FRAME_BITS-1:0] tx_shift;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) tx_state <= TX_IDLE;
      else            tx_state <= tx_next;
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         TX_IDLE:  if (i_tx_valid) tx_next = TX_LOAD;
         TX_LOAD:  if (fs_fall) tx_next = TX_SHIFT;
         TX_SHIFT: if (fs_fall && tx_cnt == 4'(FRAME_BITS)) tx_next = TX_IDLE;
         default:  tx_next = TX_IDLE;
      endcase
   end

   always_comb begin
      o_tx_ready = (tx_state == TX_IDLE);
   end

   // The last bit is held a full FSCLK period before the line returns to idle.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         tx_cnt   <= '0;
         tx_shift <= {FRAME_BITS{IDLE_LEVEL}};
         o_fsdo   <= IDLE_LEVEL;
      end else begin
         case (tx_state)
            TX_IDLE: if (i_tx_valid) tx_shift <= {TX_SOURCE, i_tx_data, START_LEVEL};
            TX_LOAD: if (fs_fall) begin
               o_fsdo   <= tx_shift[0];
               tx_shift <= {IDLE_LEVEL, tx_shift[FRAME_BITS-1:1]};
               tx_cnt   <= 4'd1;
            end
            TX_SHIFT: if (fs_fall) begin
               if (tx_cnt == 4'(FRAME_BITS)) begin
                  o_fsdo <= IDLE_LEVEL;
               end else begin
                  o_fsdo   <= tx_shift[0];
                  tx_shift <= {IDLE_LEVEL, tx_shift[FRAME_BITS-1:1]};
                  tx_cnt   <= tx_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fastserial_target.sv
// Bench: host model drives FSCLK/FSDI bit queues and decodes FSDO frames; scoreboards rx and tx bytes.
module tb_fastserial_target;
   localparam logic TXS = 1'b0;

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic       i_fsclk;
   logic       i_fsdi;
   logic       o_fsdo;
   logic       o_fscts;
   logic [7:0] o_rx_data;
   logic       o_rx_src;
   logic       o_rx_valid;
   logic       i_rx_ready;
   logic       o_rx_overrun;
   logic [7:0] i_tx_data;
   logic       i_tx_valid;
   logic       o_tx_ready;

   int total = 0;
   int bad = 0;
   int ovr_cnt = 0;
   int stall_req = 0;
   logic rdy_rand = 1'b0;
   logic rdy_val = 1'b0;
   logic rnd_bit = 1'b0;

   logic       host_q[$];
   logic [8:0] cap_q[$];
   logic [8:0] got_q[$];
   logic [8:0] exp_rx[$];
   logic [8:0] exp_tx[$];

   fastserial_target #(.SYNC_STAGES(2), .TX_SOURCE(TXS)) dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_fsclk      (i_fsclk),
      .i_fsdi       (i_fsdi),
      .o_fsdo       (o_fsdo),
      .o_fscts      (o_fscts),
      .o_rx_data    (o_rx_data),
      .o_rx_src     (o_rx_src),
      .o_rx_valid   (o_rx_valid),
      .i_rx_ready   (i_rx_ready),
      .o_rx_overrun (o_rx_overrun),
      .i_tx_data    (i_tx_data),
      .i_tx_valid   (i_tx_valid),
      .o_tx_ready   (o_tx_ready)
   );

   always #10 i_clk = ~i_clk;

   assign i_rx_ready = rdy_rand ? rnd_bit : rdy_val;

   always @(posedge i_clk) begin
      #1 rnd_bit = 1'($urandom_range(0, 1));
   end

   // Consumer and overrun monitor, sampled mid-cycle.
   always @(negedge i_clk) begin
      #2;
      if (i_reset_n && o_rx_valid && i_rx_ready) got_q.push_back({o_rx_src, o_rx_data});
      if (o_rx_overrun) ovr_cnt++;
   end

   // Host: FSCLK period 4 i_clk cycles; drive FSDI on fall, sample FSDO on rise.
   initial begin
      logic       cap_in;
      logic [8:0] cap_sh;
      int         cap_n;
      logic       stall_used;
      cap_in = 1'b0; cap_sh = '0; cap_n = 0; stall_used = 1'b0;
      i_fsclk = 1'b1;
      i_fsdi  = 1'b1;
      forever begin
         #40;
         i_fsclk = 1'b0;
         i_fsdi  = (host_q.size() != 0) ? host_q.pop_front() : 1'b1;
         #40;
         i_fsclk = 1'b1;
         if (!i_reset_n) begin
            cap_in = 1'b0;
         end else if (!cap_in) begin
            if (o_fsdo == 1'b0) begin
               cap_in = 1'b1;
               cap_n  = 0;
            end
         end else begin
            cap_sh[cap_n] = o_fsdo;
            if (cap_n == 8) begin
               cap_q.push_back(cap_sh);
               cap_in = 1'b0;
            end else begin
               cap_n++;
            end
         end
         if (stall_req != 0 && !stall_used) begin
            stall_used = 1'b1;
            #(stall_req * 20);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic host_send(input logic [7:0] d, input logic s, input int nbits);
      logic [9:0] f;
      f = {s, d, 1'b0};
      for (int i = 0; i < nbits; i++) host_q.push_back(f[i]);
   endtask

   task automatic wait_host_drain();
      int n;
      n = 0;
      while (host_q.size() != 0 && n < 30000) begin
         @(negedge i_clk);
         n++;
      end
      chk("host_drain", host_q.size(), 0);
      repeat (10) @(negedge i_clk);
   endtask

   task automatic tx_push(input logic [7:0] d);
      int n;
      n = 0;
      while (!o_tx_ready && n < 5000) begin
         @(negedge i_clk);
         n++;
      end
      chk("tx_ready_wait", o_tx_ready, 1);
      i_tx_data  = d;
      i_tx_valid = 1'b1;
      exp_tx.push_back({TXS, d});
      @(negedge i_clk);
      i_tx_valid = 1'b0;
      chk("tx_ready_drop", o_tx_ready, 0);
   endtask

   task automatic compare_rx(input string tag);
      int n;
      logic [8:0] e, g;
      n = 0;
      while (got_q.size() < exp_rx.size() && n < 30000) begin
         @(negedge i_clk);
         n++;
      end
      repeat (4) @(negedge i_clk);
      chk({tag, "_rx_count"}, got_q.size(), exp_rx.size());
      while (exp_rx.size() != 0) begin
         e = exp_rx.pop_front();
         g = (got_q.size() != 0) ? got_q.pop_front() : 9'bx;
         chk({tag, "_rx_frame"}, {23'd0, g}, {23'd0, e});
      end
      got_q.delete();
   endtask

   task automatic compare_tx(input string tag);
      int n;
      logic [8:0] e, g;
      n = 0;
      while (cap_q.size() < exp_tx.size() && n < 30000) begin
         @(negedge i_clk);
         n++;
      end
      chk({tag, "_tx_count"}, cap_q.size(), exp_tx.size());
      while (exp_tx.size() != 0) begin
         e = exp_tx.pop_front();
         g = (cap_q.size() != 0) ? cap_q.pop_front() : 9'bx;
         chk({tag, "_tx_frame"}, {23'd0, g}, {23'd0, e});
      end
      cap_q.delete();
   endtask

   initial begin
      int n;
      int ovr0;
      logic [7:0] d;
      i_reset_n  = 1'b0;
      i_tx_data  = '0;
      i_tx_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("rst_fsdo", o_fsdo, 1);
      chk("rst_fscts", o_fscts, 1);
      chk("rst_rx_valid", o_rx_valid, 0);
      chk("rst_rx_data", o_rx_data, 0);
      chk("rst_rx_src", o_rx_src, 0);
      chk("rst_overrun", o_rx_overrun, 0);
      chk("rst_tx_ready", o_tx_ready, 1);
      i_reset_n = 1'b1;
      repeat (10) @(negedge i_clk);

      // Frame held in buffer while the consumer is not ready.
      rdy_val = 1'b0;
      host_send(8'hA5, 1'b1, 10);
      repeat (20) @(negedge i_clk);
      chk("cts_mid_frame", o_fscts, 0);
      wait_host_drain();
      chk("a5_valid", o_rx_valid, 1);
      chk("a5_data", o_rx_data, 8'hA5);
      chk("a5_src", o_rx_src, 1);
      chk("a5_cts_full", o_fscts, 0);

      // Second frame into a full buffer.
      ovr0 = ovr_cnt;
      host_send(8'h3C, 1'b0, 10);
      wait_host_drain();
      chk("ovr_pulses", ovr_cnt - ovr0, 1);
      chk("ovr_keep_data", o_rx_data, 8'hA5);
      chk("ovr_keep_valid", o_rx_valid, 1);

      // One-cycle ready pulse drains the buffer; CTS returns one cycle later.
      rdy_val = 1'b1;
      @(negedge i_clk);
      rdy_val = 1'b0;
      chk("drain_valid", o_rx_valid, 0);
      chk("drain_cts_lag", o_fscts, 0);
      @(negedge i_clk);
      chk("drain_cts", o_fscts, 1);
      exp_rx.push_back({1'b1, 8'hA5});
      compare_rx("a5");

      // Transmit 0x81.
      tx_push(8'h81);
      n = 0;
      while (cap_q.size() == 0 && n < 2000) begin
         @(negedge i_clk);
         n++;
      end
      chk("tx81_ready_low", o_tx_ready, 0);
      compare_tx("tx81");
      repeat (20) @(negedge i_clk);
      chk("tx81_ready_back", o_tx_ready, 1);
      chk("tx81_idle", o_fsdo, 1);

      // Full duplex.
      rdy_val = 1'b1;
      fork
         tx_push(8'h55);
         begin
            host_send(8'hF0, 1'b1, 10);
            exp_rx.push_back({1'b1, 8'hF0});
         end
      join
      wait_host_drain();
      compare_rx("dup");
      compare_tx("dup");

      // Reset in the middle of both directions.
      tx_push(8'h00);
      host_send(8'h6B, 1'b0, 5);
      wait_host_drain();
      chk("pre_rst_fscts", o_fscts, 0);
      chk("pre_rst_fsdo", o_fsdo, 0);
      i_reset_n = 1'b0;
      #1;
      chk("mid_rst_fsdo", o_fsdo, 1);
      chk("mid_rst_fscts", o_fscts, 1);
      chk("mid_rst_tx_ready", o_tx_ready, 1);
      repeat (6) @(negedge i_clk);
      i_reset_n = 1'b1;
      exp_tx.delete();
      repeat (40) @(negedge i_clk);
      chk("no_junk_rx", got_q.size(), 0);
      chk("no_junk_tx", cap_q.size(), 0);
      host_send(8'h12, 1'b0, 10);
      exp_rx.push_back({1'b0, 8'h12});
      tx_push(8'h12);
      wait_host_drain();
      compare_rx("post_rst");
      compare_tx("post_rst");

      // FSCLK stalled high mid-frame.
      tx_push(8'h5A);
      host_send(8'hC3, 1'b1, 10);
      exp_rx.push_back({1'b1, 8'hC3});
      repeat (20) @(negedge i_clk);
      stall_req = 1000;
      repeat (500) @(negedge i_clk);
      chk("stall_clk_high", i_fsclk, 1);
      chk("stall_no_valid", o_rx_valid, 0);
      chk("stall_cts", o_fscts, 0);
      chk("stall_tx_busy", o_tx_ready, 0);
      wait_host_drain();
      compare_rx("stall");
      compare_tx("stall");

      // Random traffic both ways with a random consumer.
      rdy_rand = 1'b1;
      fork
         for (int i = 0; i < 10; i++) begin
            logic [7:0] rd;
            logic       rs;
            rd = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            host_send(rd, rs, 10);
            exp_rx.push_back({rs, rd});
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) host_q.push_back(1'b1);
         end
         for (int j = 0; j < 10; j++) begin
            d = 8'($urandom);
            tx_push(d);
         end
      join
      wait_host_drain();
      compare_rx("rand");
      compare_tx("rand");
      chk("overrun_total", ovr_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
